// File: rtl/syn_fifo_pkg.sv
// Shared types and width helpers for the bus-width-matching FIFO family.
package syn_fifo_pkg;

   typedef enum logic {LITTLE_E, BIG_E} endian_e;

   function automatic int unsigned min_f(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

   function automatic int unsigned ratio_f(input int unsigned a, input int unsigned b);
      return (a > b) ? a / b : b / a;
   endfunction

   function automatic bit is_pow2_f(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

   // Granule width and lane counts derived from the two bus widths.
   function automatic int unsigned gran_f(input int unsigned wr_w, input int unsigned rd_w);
      return min_f(wr_w, rd_w);
   endfunction

   function automatic int unsigned lanes_f(input int unsigned w, input int unsigned wr_w,
                                           input int unsigned rd_w);
      return w / min_f(wr_w, rd_w);
   endfunction

endpackage

// File: rtl/syn_fifo_ram.sv
// Simple dual-port granule RAM: WR_G-lane write port, RD_G-lane registered read port.
module syn_fifo_ram #(
   parameter int unsigned G     = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WR_G  = 4,
   parameter int unsigned RD_G  = 1,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [WR_G*G-1:0]    wdata,
   input  logic                 re,
   input  logic [AW-1:0]        raddr,
   output logic [RD_G*G-1:0]    rdata
);

   logic [G-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int j = 0; j < WR_G; j++) begin
            mem[waddr + AW'(j)] <= wdata[j*G +: G];
         end
      end
   end

   // Only the read register is reset; the array keeps stale contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         for (int j = 0; j < RD_G; j++) begin
            rdata[j*G +: G] <= mem[raddr + AW'(j)];
         end
      end
   end

endmodule

// File: rtl/syn_fifo_bm.sv
// Single-clock FIFO with bus-width matching, lane-order select and almost flags.
// Optional sticky ovf_o/udf_o outputs are enabled by defining SYN_FIFO_ERR_FLAGS_EN.
module syn_fifo_bm
   import syn_fifo_pkg::*;
#(
   parameter int unsigned FIFO_ENTRIES = 16,
   parameter int unsigned WR_WIDTH     = 32,
   parameter int unsigned RD_WIDTH     = 8,
   localparam int unsigned CNT_W       = $clog2(FIFO_ENTRIES) + 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                big_en_i,
   input  logic                wr_i,
   input  logic [WR_WIDTH-1:0] data_in_i,
   input  logic                rd_i,
   output logic [RD_WIDTH-1:0] data_out_o,
   output logic                data_vld_o,
   input  logic [CNT_W-1:0]    af_offset_i,
   input  logic [CNT_W-1:0]    ae_offset_i,
   output logic                fifo_empty_o,
   output logic                fifo_full_o,
   output logic                half_full_o,
   output logic                af_o,
   output logic                ae_o,
`ifdef SYN_FIFO_ERR_FLAGS_EN
   output logic                ovf_o,
   output logic                udf_o,
`endif
   output logic [CNT_W-1:0]    fill_cnt_o
);

   localparam int unsigned G    = gran_f(WR_WIDTH, RD_WIDTH);
   localparam int unsigned WR_G = lanes_f(WR_WIDTH, WR_WIDTH, RD_WIDTH);
   localparam int unsigned RD_G = lanes_f(RD_WIDTH, WR_WIDTH, RD_WIDTH);
   localparam int unsigned AW   = $clog2(FIFO_ENTRIES);

   initial begin
      assert (is_pow2_f(FIFO_ENTRIES) && FIFO_ENTRIES >= 4)
         else $error("syn_fifo_bm: FIFO_ENTRIES must be a power of two >= 4");
      assert (is_pow2_f(ratio_f(WR_WIDTH, RD_WIDTH)) &&
              (WR_WIDTH > RD_WIDTH ? WR_WIDTH % RD_WIDTH : RD_WIDTH % WR_WIDTH) == 0)
         else $error("syn_fifo_bm: bus widths must differ by a power-of-two factor");
      assert (FIFO_ENTRIES % ratio_f(WR_WIDTH, RD_WIDTH) == 0)
         else $error("syn_fifo_bm: FIFO_ENTRIES must be a multiple of the width ratio");
   end

   endian_e          endian_q;
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CNT_W-1:0] count_q, count_d, free;
   logic             vld_q, wr_acc, rd_acc;
   logic [WR_WIDTH-1:0] wr_lanes;
   logic [RD_WIDTH-1:0] rd_lanes;

   assign free   = CNT_W'(FIFO_ENTRIES) - count_q;
   assign wr_acc = wr_i & ~rst_i & (free >= CNT_W'(WR_G));
   assign rd_acc = rd_i & ~rst_i & (count_q >= CNT_W'(RD_G));

   always_comb begin
      count_d = count_q;
      if (wr_acc) count_d = count_d + CNT_W'(WR_G);
      if (rd_acc) count_d = count_d - CNT_W'(RD_G);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         endian_q <= endian_e'(big_en_i);
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         vld_q    <= 1'b0;
      end else begin
         if (wr_acc) wptr_q <= wptr_q + AW'(WR_G);
         if (rd_acc) rptr_q <= rptr_q + AW'(RD_G);
         count_q <= count_d;
         vld_q   <= rd_acc;
      end
   end

   // RAM lanes are in FIFO order; lane order only affects the bus-side mapping.
   always_comb begin
      wr_lanes = '0;
      for (int j = 0; j < WR_G; j++) begin
         wr_lanes[j*G +: G] = (endian_q == BIG_E) ? data_in_i[(WR_G-1-j)*G +: G]
                                                  : data_in_i[j*G +: G];
      end
   end

   always_comb begin
      data_out_o = '0;
      for (int j = 0; j < RD_G; j++) begin
         if (endian_q == BIG_E) data_out_o[(RD_G-1-j)*G +: G] = rd_lanes[j*G +: G];
         else                   data_out_o[j*G +: G]          = rd_lanes[j*G +: G];
      end
   end

   syn_fifo_ram #(
      .G     (G),
      .DEPTH (FIFO_ENTRIES),
      .WR_G  (WR_G),
      .RD_G  (RD_G)
   ) u_ram (
      .clk   (clk_i),
      .rst   (rst_i),
      .we    (wr_acc),
      .waddr (wptr_q),
      .wdata (wr_lanes),
      .re    (rd_acc),
      .raddr (rptr_q),
      .rdata (rd_lanes)
   );

   assign data_vld_o   = vld_q;
   assign fill_cnt_o   = count_q;
   assign fifo_empty_o = count_q < CNT_W'(RD_G);
   assign fifo_full_o  = free < CNT_W'(WR_G);
   assign half_full_o  = count_q >= CNT_W'(FIFO_ENTRIES / 2);
   assign af_o = (af_offset_i >= CNT_W'(FIFO_ENTRIES)) ||
                 (count_q >= CNT_W'(FIFO_ENTRIES) - af_offset_i);
   assign ae_o = (ae_offset_i >= CNT_W'(FIFO_ENTRIES)) || (count_q <= ae_offset_i);

`ifdef SYN_FIFO_ERR_FLAGS_EN
   logic ovf_q, udf_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (wr_i && fifo_full_o)  ovf_q <= 1'b1;
         if (rd_i && fifo_empty_o) udf_q <= 1'b1;
      end
   end

   assign ovf_o = ovf_q;
   assign udf_o = udf_q;
`endif

endmodule

// File: tb/tb_syn_fifo_bm.sv
// Self-checking bench for syn_fifo_bm (32-bit write, 8-bit read, 16 granules).
module tb_syn_fifo_bm;

   localparam int ENTRIES = 16;
   localparam int WR_G    = 4;

   logic        clk = 1'b0;
   logic        rst, big_en, wr, rd;
   logic [31:0] din;
   logic [7:0]  dout;
   logic        vld, empty, full, half, af, ae;
   logic [4:0]  af_off, ae_off, fill;
`ifdef SYN_FIFO_ERR_FLAGS_EN
   logic        ovf, udf;
   bit          m_ovf, m_udf;
`endif

   byte unsigned q[$];
   logic [7:0]   m_dout;
   bit           m_vld, m_big;
   int           n_checks = 0;
   int           n_fail   = 0;

   always #5 clk = ~clk;

   syn_fifo_bm dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .big_en_i     (big_en),
      .wr_i         (wr),
      .data_in_i    (din),
      .rd_i         (rd),
      .data_out_o   (dout),
      .data_vld_o   (vld),
      .af_offset_i  (af_off),
      .ae_offset_i  (ae_off),
      .fifo_empty_o (empty),
      .fifo_full_o  (full),
      .half_full_o  (half),
      .af_o         (af),
      .ae_o         (ae),
`ifdef SYN_FIFO_ERR_FLAGS_EN
      .ovf_o        (ovf),
      .udf_o        (udf),
`endif
      .fill_cnt_o   (fill)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
         else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
   endtask

   task automatic check_all();
      int n = q.size();
      chk("fill_cnt",   32'(fill),  32'(n));
      chk("fifo_empty", 32'(empty), 32'(n < 1));
      chk("fifo_full",  32'(full),  32'((ENTRIES - n) < WR_G));
      chk("half_full",  32'(half),  32'(n >= ENTRIES / 2));
      chk("af",         32'(af),    32'((int'(af_off) >= ENTRIES) || (n >= ENTRIES - int'(af_off))));
      chk("ae",         32'(ae),    32'((int'(ae_off) >= ENTRIES) || (n <= int'(ae_off))));
      chk("data_vld",   32'(vld),   32'(m_vld));
      chk("data_out",   32'(dout),  32'(m_dout));
`ifdef SYN_FIFO_ERR_FLAGS_EN
      chk("ovf",        32'(ovf),   32'(m_ovf));
      chk("udf",        32'(udf),   32'(m_udf));
`endif
   endtask

   // Drive one cycle, advance the byte-queue model, then compare after the edge.
   task automatic step(input bit w, input logic [31:0] d, input bit r, input bit rs);
      bit wok, rok;
      rst = rs; wr = w; din = d; rd = r;
      if (rs) begin
         q.delete();
         m_vld = 0; m_dout = '0; m_big = big_en;
`ifdef SYN_FIFO_ERR_FLAGS_EN
         m_ovf = 0; m_udf = 0;
`endif
      end else begin
         wok = w && (ENTRIES - q.size() >= WR_G);
         rok = r && (q.size() >= 1);
`ifdef SYN_FIFO_ERR_FLAGS_EN
         if (w && !wok) m_ovf = 1;
         if (r && !rok) m_udf = 1;
`endif
         m_vld = rok;
         if (rok) m_dout = q.pop_front();
         if (wok) begin
            for (int j = 0; j < WR_G; j++) begin
               q.push_back(m_big ? d[(WR_G-1-j)*8 +: 8] : d[j*8 +: 8]);
            end
         end
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset(input bit be);
      big_en = be;
      step(0, '0, 0, 1);
      step(0, '0, 0, 1);
      step(0, '0, 0, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() > 0; i++) step(0, '0, 1, 0);
      step(0, '0, 0, 0);
   endtask

   initial begin
      rst = 1; big_en = 0; wr = 0; rd = 0; din = '0;
      af_off = 5'd4; ae_off = 5'd2;
      m_vld = 0; m_dout = '0; m_big = 0;

      // Little-endian unpacking.
      do_reset(0);
      step(1, 32'hAABBCCDD, 0, 0);
      step(0, '0, 1, 0); chk("le_b0", 32'(dout), 32'hDD);
      step(0, '0, 1, 0); chk("le_b1", 32'(dout), 32'hCC);
      step(0, '0, 1, 0); chk("le_b2", 32'(dout), 32'hBB);
      step(0, '0, 1, 0); chk("le_b3", 32'(dout), 32'hAA);
      step(0, '0, 0, 0); chk("le_empty", 32'(empty), 32'd1);

      // Big-endian unpacking.
      do_reset(1);
      step(1, 32'hAABBCCDD, 0, 0);
      step(0, '0, 1, 0); chk("be_b0", 32'(dout), 32'hAA);
      step(0, '0, 1, 0); chk("be_b1", 32'(dout), 32'hBB);
      step(0, '0, 1, 0); chk("be_b2", 32'(dout), 32'hCC);
      step(0, '0, 1, 0); chk("be_b3", 32'(dout), 32'hDD);
      step(0, '0, 0, 0);

      // Full boundary.
      do_reset(0);
      for (int i = 0; i < 4; i++) step(1, $urandom, 0, 0);
      chk("full_cnt", 32'(fill), 32'd16);
      step(1, $urandom, 0, 0);
      chk("full_refused", 32'(fill), 32'd16);
      step(0, '0, 1, 0);
      chk("full_after_rd", 32'(full), 32'd1);
      drain();

      // Simultaneous write and read at count 4; then underflow at count 0.
      step(1, $urandom, 0, 0);
      step(1, $urandom, 1, 0);
      chk("simul_cnt", 32'(fill), 32'd7);
      drain();
      step(0, '0, 1, 0);
      chk("udf_vld", 32'(vld), 32'd0);
      step(0, '0, 0, 0);

      // Thresholds.
      for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
      chk("af_at_12", 32'(af), 32'd1);
      for (int i = 0; i < 10; i++) step(0, '0, 1, 0);
      chk("ae_at_2", 32'(ae), 32'd1);
      drain();

      // Repeated fill/drain so the pointers wrap.
      for (int c = 0; c < 10; c++) begin
         for (int i = 0; i < 4; i++) step(1, $urandom, 0, 0);
         drain();
      end

      // Random traffic, both lane orders.
      for (int e = 0; e < 2; e++) begin
         do_reset(e[0]);
         for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 2) != 0), 0);
         end
      end

      // Saturated offsets.
      af_off = 5'd20; ae_off = 5'd17;
      do_reset(0);
      for (int i = 0; i < 4; i++) step(1, $urandom, 0, 0);
      drain();
      af_off = 5'd4; ae_off = 5'd2;

      // Reset mid-stream with a write pending.
      do_reset(0);
      step(1, $urandom, 0, 0);
      step(1, $urandom, 0, 0);
      step(0, '0, 1, 0);
      step(1, $urandom, 1, 1);
      chk("rst_cnt", 32'(fill), 32'd0);
      chk("rst_vld", 32'(vld), 32'd0);
      step(0, '0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
